// File: rtl/rv_alu_pkg.sv
// rv_alu_pkg: shared constants for the RV32 ALU.
//   WIDTH      - datapath width (only 32 is supported)
//   ALU_*      - 3-bit operation codes driven on ALUControl
package rv_alu_pkg;

   localparam int WIDTH = 32;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_XOR = 3'b100;
   localparam logic [2:0] ALU_SLL = 3'b101;
   localparam logic [2:0] ALU_SRL = 3'b110;
   localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/rv_alu_addsub.sv
// rv_alu_addsub: single shared adder for ADD, SUB and SLT.
//   a, b  - operands (two's complement)
//   sub   - 1 selects a - b, 0 selects a + b
//   sum   - a + (b ^ {WIDTH{sub}}) + sub, modulo 2^WIDTH
//   v     - signed overflow of that addition
module rv_alu_addsub
   import rv_alu_pkg::*;
(
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   output logic [WIDTH-1:0] sum,
   output logic             v
);

   logic [WIDTH-1:0] b_eff;

   always_comb begin
      // Subtraction as a plus inverted b plus one: one carry chain serves all three ops.
      b_eff = b ^ {WIDTH{sub}};
      sum   = a + b_eff + {{(WIDTH-1){1'b0}}, sub};
      // Overflow when the effective addends agree in sign but the sum does not.
      // Using b_eff covers SUB too, including b = most-negative value.
      v     = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
   end

endmodule

// File: rtl/rv_alu.sv
// rv_alu: 32-bit RV32 integer ALU with registered result and flags.
//   clk, rst_n  - clock (rising edge) and asynchronous active-low reset
//   A, B        - operands; B[4:0] is the shift amount for SLL/SRL
//   ALUControl  - operation select (see rv_alu_pkg ALU_* codes)
//   Result      - registered result, one cycle after the inputs
//   V, N, Zero  - registered overflow, negative and zero flags
module rv_alu #(
   parameter int WIDTH = rv_alu_pkg::WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [2:0]       ALUControl,
   output logic [WIDTH-1:0] Result,
   output logic             V,
   output logic             N,
   output logic             Zero
);

   import rv_alu_pkg::*;

   logic [WIDTH-1:0] as_sum;
   logic             as_v;
   logic             as_sub;
   logic [4:0]       shamt;

   logic [WIDTH-1:0] result_d, result_q;
   logic             v_d, v_q;
   logic             n_d, n_q;
   logic             zero_d, zero_q;

   // SLT reuses the subtractor, so only ADD runs the adder in add mode.
   assign as_sub = (ALUControl != ALU_ADD);
   assign shamt  = B[4:0];

   rv_alu_addsub u_addsub (
      .a   (A),
      .b   (B),
      .sub (as_sub),
      .sum (as_sum),
      .v   (as_v)
   );

   always_comb begin
      result_d = '0;
      v_d      = 1'b0;
      unique case (ALUControl)
         ALU_ADD: begin result_d = as_sum; v_d = as_v; end
         ALU_SUB: begin result_d = as_sum; v_d = as_v; end
         ALU_AND: result_d = A & B;
         ALU_OR:  result_d = A | B;
         ALU_XOR: result_d = A ^ B;
         ALU_SLL: result_d = A << shamt;
         ALU_SRL: result_d = A >> shamt;
         // Sign of the difference corrected by overflow gives true signed less-than.
         ALU_SLT: result_d = {{(WIDTH-1){1'b0}}, as_sum[WIDTH-1] ^ as_v};
         default: result_d = '0;
      endcase
      // Flags derive from the exact value being registered as Result.
      n_d    = result_d[WIDTH-1];
      zero_d = (result_d == '0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         result_q <= '0;
         v_q      <= 1'b0;
         n_q      <= 1'b0;
         zero_q   <= 1'b1;   // consistent with Result = 0
      end else begin
         result_q <= result_d;
         v_q      <= v_d;
         n_q      <= n_d;
         zero_q   <= zero_d;
      end
   end

   assign Result = result_q;
   assign V      = v_q;
   assign N      = n_q;
   assign Zero   = zero_q;

endmodule

// File: tb/tb_rv_alu.sv
module tb_rv_alu;

   logic        clk;
   logic        rst_n;
   logic [31:0] A, B;
   logic [2:0]  ALUControl;
   logic [31:0] Result;
   logic        V, N, Zero;

   int checks   = 0;
   int failures = 0;

   localparam longint MAXS = 64'sd2147483647;
   localparam longint MINS = -64'sd2147483648;

   rv_alu dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .A          (A),
      .B          (B),
      .ALUControl (ALUControl),
      .Result     (Result),
      .V          (V),
      .N          (N),
      .Zero       (Zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model from arithmetic rules: returns {result, V, N, Zero}.
   function automatic logic [34:0] model(input logic [31:0] a, input logic [31:0] b,
                                         input logic [2:0] op);
      longint sa, sb, t;
      logic [31:0] r;
      logic v;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      t  = 0;
      r  = '0;
      v  = 1'b0;
      case (op)
         3'd0: begin t = sa + sb; r = t[31:0]; v = (t > MAXS) || (t < MINS); end
         3'd1: begin t = sa - sb; r = t[31:0]; v = (t > MAXS) || (t < MINS); end
         3'd2: r = a & b;
         3'd3: r = a | b;
         3'd4: r = a ^ b;
         3'd5: r = a << (b % 32);
         3'd6: r = a >> (b % 32);
         default: r = (sa < sb) ? 32'd1 : 32'd0;
      endcase
      return {r, v, r[31], r == 32'd0};
   endfunction

   // Drive inputs then advance past one rising edge; outputs sampled 1ns later.
   task automatic apply(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
      A = a; B = b; ALUControl = op;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst_n = 1'b0; A = 32'd5; B = 32'd7; ALUControl = 3'd0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({Result, V, N, Zero} !== {32'd0, 1'b0, 1'b0, 1'b1}) begin
         failures++;
         $display("FAIL reset_state got R=%h V=%b N=%b Z=%b want R=0 V=0 N=0 Z=1", Result, V, N, Zero);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   typedef struct { logic [31:0] a; logic [31:0] b; logic [2:0] op; logic [34:0] exp; string name; } vec_t;

   task automatic test_directed;
      vec_t v[$];
      v.push_back('{32'd124, 32'd73, 3'd0, {32'd197, 1'b0, 1'b0, 1'b0}, "add_pos"});
      v.push_back('{-32'd124, -32'd73, 3'd0, {-32'd197, 1'b0, 1'b1, 1'b0}, "add_neg"});
      v.push_back('{32'd124, 32'd124, 3'd1, {32'd0, 1'b0, 1'b0, 1'b1}, "sub_zero"});
      v.push_back('{32'd20, 32'd120, 3'd1, {-32'd100, 1'b0, 1'b1, 1'b0}, "sub_neg"});
      v.push_back('{-32'd20, -32'd120, 3'd1, {32'd100, 1'b0, 1'b0, 1'b0}, "sub_pos"});
      v.push_back('{32'h7FFFFFFF, 32'd1, 3'd0, {32'h80000000, 1'b1, 1'b1, 1'b0}, "add_ovf"});
      v.push_back('{32'h80000000, 32'd1, 3'd1, {32'h7FFFFFFF, 1'b1, 1'b0, 1'b0}, "sub_ovf"});
      v.push_back('{32'h80000000, 32'd1, 3'd7, {32'd1, 1'b0, 1'b0, 1'b0}, "slt_ovf"});
      v.push_back('{32'd124, 32'd73, 3'd2, {32'd72, 1'b0, 1'b0, 1'b0}, "and"});
      v.push_back('{32'd124, 32'd73, 3'd3, {32'd125, 1'b0, 1'b0, 1'b0}, "or"});
      v.push_back('{32'd124, 32'd73, 3'd4, {32'd53, 1'b0, 1'b0, 1'b0}, "xor"});
      v.push_back('{32'd124, 32'd73, 3'd5, {32'd63488, 1'b0, 1'b0, 1'b0}, "sll"});
      v.push_back('{32'd124, 32'd73, 3'd6, {32'd0, 1'b0, 1'b0, 1'b1}, "srl_zero"});
      v.push_back('{32'd124, 32'd73, 3'd7, {32'd0, 1'b0, 1'b0, 1'b1}, "slt_false"});
      v.push_back('{32'hDEADBEEF, 32'hFFFFFFE0, 3'd5, {32'hDEADBEEF, 1'b0, 1'b1, 1'b0}, "sll_sh0"});
      v.push_back('{32'hDEADBEEF, 32'h00000020, 3'd6, {32'hDEADBEEF, 1'b0, 1'b1, 1'b0}, "srl_sh0"});
      v.push_back('{32'd0, 32'h80000000, 3'd1, {32'h80000000, 1'b1, 1'b1, 1'b0}, "sub_minneg"});
      foreach (v[i]) begin
         apply(v[i].a, v[i].b, v[i].op);
         checks++;
         if ({Result, V, N, Zero} !== v[i].exp) begin
            failures++;
            $display("FAIL %s got R=%h V=%b N=%b Z=%b want R=%h V=%b N=%b Z=%b", v[i].name,
                     Result, V, N, Zero, v[i].exp[34:3], v[i].exp[2], v[i].exp[1], v[i].exp[0]);
         end
      end
   endtask

   task automatic test_random;
      logic [31:0] corner[6];
      logic [31:0] a, b;
      logic [2:0]  op;
      logic [34:0] exp;
      corner = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h80000000, 32'h80000001};
      for (int i = 0; i < 300; i++) begin
         a  = ($urandom_range(3) == 0) ? corner[$urandom_range(5)] : $urandom;
         b  = ($urandom_range(3) == 0) ? corner[$urandom_range(5)] : $urandom;
         op = 3'($urandom_range(7));
         exp = model(a, b, op);
         apply(a, b, op);
         checks++;
         if ({Result, V, N, Zero} !== exp) begin
            failures++;
            $display("FAIL random op=%0d a=%h b=%h got R=%h V=%b N=%b Z=%b want R=%h V=%b N=%b Z=%b",
                     op, a, b, Result, V, N, Zero, exp[34:3], exp[2], exp[1], exp[0]);
         end
      end
   endtask

   task automatic test_back_to_back;
      logic [31:0] a, b;
      logic [34:0] exp;
      for (int op = 0; op < 8; op++) begin
         a   = $urandom;
         b   = $urandom;
         exp = model(a, b, 3'(op));
         apply(a, b, 3'(op));
         checks++;
         if ({Result, V, N, Zero} !== exp) begin
            failures++;
            $display("FAIL b2b op=%0d got R=%h V=%b N=%b Z=%b want R=%h V=%b N=%b Z=%b",
                     op, Result, V, N, Zero, exp[34:3], exp[2], exp[1], exp[0]);
         end
      end
   endtask

   task automatic test_async_reset;
      logic [34:0] exp;
      // Hold between edges: outputs must not follow a new input until the clock rises.
      apply(32'd124, 32'd73, 3'd0);
      A = 32'd1; B = 32'd1; ALUControl = 3'd4;
      #3;
      checks++;
      if (Result !== 32'd197) begin
         failures++;
         $display("FAIL hold_between_edges got R=%h want R=%h", Result, 32'd197);
      end
      // Mid-cycle reset: takes effect without a clock edge.
      rst_n = 1'b0;
      #1;
      checks++;
      if ({Result, V, N, Zero} !== {32'd0, 1'b0, 1'b0, 1'b1}) begin
         failures++;
         $display("FAIL async_reset got R=%h V=%b N=%b Z=%b want R=0 V=0 N=0 Z=1", Result, V, N, Zero);
      end
      A = 32'h7FFFFFFF; B = 32'd1; ALUControl = 3'd0;
      @(posedge clk);
      #1;
      checks++;
      if ({Result, V, N, Zero} !== {32'd0, 1'b0, 1'b0, 1'b1}) begin
         failures++;
         $display("FAIL reset_held got R=%h V=%b N=%b Z=%b want R=0 V=0 N=0 Z=1", Result, V, N, Zero);
      end
      @(negedge clk);
      rst_n = 1'b1;
      exp = model(32'h7FFFFFFF, 32'd1, 3'd0);
      @(posedge clk);
      #1;
      checks++;
      if ({Result, V, N, Zero} !== exp) begin
         failures++;
         $display("FAIL first_after_reset got R=%h V=%b N=%b Z=%b want R=%h V=%b N=%b Z=%b",
                  Result, V, N, Zero, exp[34:3], exp[2], exp[1], exp[0]);
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_back_to_back();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
